alu_unit: RTL
=============

// Module: alu_unit
// PURPOSE
//  Integer execution stage directly downstream of the reservation station (RS). Takes one
//  dispatched op per cycle (alu_op/Vi/Vj/imm/rd/pc as RS drives them). Computes the RV32I
//  ALU, branch and jump result, registers it, and broadcasts it on the ALU result bus.
//  That bus feeds the RS wakeup (alu_ready/alu_ROB_id/alu_val), the ROB and branch resolution.
// PARAMETERS
//  OP_W    7   alu_op width (= `RS_TYPE); bit OP_W-1 = use_imm, bits OP_W-2:0 = op code
//  ROB_W   5   ROB tag width
//  XLEN    32  datapath width
// PORTS
//  clk_in      in   1      system clock
//  rst_in      in   1      reset; asynchronous, active-low
//  rdy_in      in   1      global enable; low = hold all state and outputs
//  clear_flag  in   1      pipeline flush (mispredict), synchronous
//  alu_op      in   OP_W   op from RS; op code 0 = NOP / no issue this cycle
//  Vi, Vj      in   XLEN   operands A, B
//  imm         in   XLEN   immediate; replaces Vj as operand B when use_imm=1
//  rd          in   ROB_W  destination ROB tag
//  pc          in   XLEN   instruction PC
//  busy        out  1      RS must not issue this cycle (multi-cycle op in flight)
//  alu_ready   out  1      result valid, one-cycle pulse
//  alu_ROB_id  out  ROB_W  tag of the result
//  alu_val     out  XLEN   result value
//  br_valid    out  1      result belongs to a branch or jump
//  br_taken    out  1      branch/jump taken
//  br_target   out  XLEN   redirect target
// BEHAVIOUR
//  - Reset (rst_in=0, async): all outputs 0, FSM=IDLE, product reg 0.
//  - Op codes: 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND,
//    11 BEQ, 12 BNE, 13 BLT, 14 BGE, 15 BLTU, 16 BGEU, 17 JAL, 18 JALR, 19 LUI, 20 AUIPC;
//    22-25 MUL/MULH/MULHSU/MULHU only with ALU_MUL_EN.
//  - Accept: at posedge with rdy_in=1, clear_flag=0, op!=0, state IDLE.
//  - Single-cycle ops: result registered at the accepting edge; alu_ready=1 for exactly the
//    next cycle, then 0 unless a new op was accepted. Back-to-back issue every cycle is allowed.
//  - Shifts use B[4:0]. SLT/SLTU produce 0/1. LUI -> imm. AUIPC -> pc+imm.
//    All arithmetic wraps modulo 2^XLEN.
//  - Conditional branches: br_valid=1, alu_val={31'b0,taken}, br_target = taken ? pc+imm : pc+4.
//  - JAL: alu_val=pc+4, br_taken=1, br_target=pc+imm.
//  - JALR: alu_val=pc+4, br_taken=1, br_target=(Vi+imm)&~1.
//  - Non-branch ops: br_valid, br_taken and br_target are 0.
//  - Undefined op codes: accepted, alu_ready=1, alu_val=0, br_valid=0.
//  - clear_flag=1 (takes priority over accept): next cycle alu_ready=0 and br_valid=0;
//    FSM to IDLE; any in-flight multiply is discarded.
//  - rdy_in=0: no state change, and outputs hold (including a pending alu_ready).
//  - FSM: IDLE -(accept MUL op)-> MUL -(next enabled edge)-> IDLE, result output.
//    busy = (state==MUL).
//  - Issue while busy=1 is a protocol violation: the op is ignored, and the bench asserts on it.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - MUL ops take 2 edges: edge 1 latches the 64-bit product into the product reg;
//     edge 2 drives alu_ready with the low (MUL) or high (MULH*) word.
//   - busy is high for one cycle in between.
//  ALU_MUL_EN undefined:
//   - No multiplier, FSM stays IDLE, busy tied 0.
//   - Op codes 22-25 follow the undefined-op rule.
// STRUCTURE
//  - Op code localparams (ALU_OP_*, ALU_USE_IMM bit) go in the shared const.v, used by the
//    decoder, RS and this block.
//  - Sub-module alu_mul (signed/unsigned 33x33 product register plus high/low select),
//    instantiated only under ALU_MUL_EN. Compare and shift logic stays inline.
// TESTING
//  1. ADD Vi=5 Vj=7 rd=3 -> next cycle alu_ready=1, alu_ROB_id=3, alu_val=12; then alu_ready=0.
//  2. SRA|use_imm Vi=0x80000000 imm=4 -> alu_val=0xF8000000. SLTU Vi=1 Vj=0xFFFFFFFF -> 1.
//  3. BLT Vi=0xFFFFFFFF Vj=1 pc=0x100 imm=0x20 -> br_valid=1, br_taken=1, br_target=0x120,
//     alu_val=1.
//  4. JALR Vi=0x1003 imm=4 pc=0x40 -> br_target=0x1006, alu_val=0x44.
//  5. Two ops on consecutive cycles, then clear_flag together with a third op
//     -> two pulses, third suppressed.
//  6. [ALU_MUL_EN] MULHU 0xFFFFFFFF*2 -> busy=1 one cycle, then alu_val=1.
//     clear_flag in the busy cycle -> no alu_ready. rst_in low mid-op -> all outputs 0 at once.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared constants and types for the integer ALU stage: op codes, widths, FSM states.
// Op codes 22-25 (multiply) are only meaningful when ALU_MUL_EN is defined.
package alu_unit_pkg;

  localparam int OP_W        = 7;
  localparam int ROB_W       = 5;
  localparam int XLEN        = 32;
  localparam int ALU_USE_IMM = OP_W - 1;

  localparam logic [OP_W-2:0] ALU_OP_NOP    = 6'd0;
  localparam logic [OP_W-2:0] ALU_OP_ADD    = 6'd1;
  localparam logic [OP_W-2:0] ALU_OP_SUB    = 6'd2;
  localparam logic [OP_W-2:0] ALU_OP_SLL    = 6'd3;
  localparam logic [OP_W-2:0] ALU_OP_SLT    = 6'd4;
  localparam logic [OP_W-2:0] ALU_OP_SLTU   = 6'd5;
  localparam logic [OP_W-2:0] ALU_OP_XOR    = 6'd6;
  localparam logic [OP_W-2:0] ALU_OP_SRL    = 6'd7;
  localparam logic [OP_W-2:0] ALU_OP_SRA    = 6'd8;
  localparam logic [OP_W-2:0] ALU_OP_OR     = 6'd9;
  localparam logic [OP_W-2:0] ALU_OP_AND    = 6'd10;
  localparam logic [OP_W-2:0] ALU_OP_BEQ    = 6'd11;
  localparam logic [OP_W-2:0] ALU_OP_BNE    = 6'd12;
  localparam logic [OP_W-2:0] ALU_OP_BLT    = 6'd13;
  localparam logic [OP_W-2:0] ALU_OP_BGE    = 6'd14;
  localparam logic [OP_W-2:0] ALU_OP_BLTU   = 6'd15;
  localparam logic [OP_W-2:0] ALU_OP_BGEU   = 6'd16;
  localparam logic [OP_W-2:0] ALU_OP_JAL    = 6'd17;
  localparam logic [OP_W-2:0] ALU_OP_JALR   = 6'd18;
  localparam logic [OP_W-2:0] ALU_OP_LUI    = 6'd19;
  localparam logic [OP_W-2:0] ALU_OP_AUIPC  = 6'd20;
  localparam logic [OP_W-2:0] ALU_OP_MUL    = 6'd22;
  localparam logic [OP_W-2:0] ALU_OP_MULH   = 6'd23;
  localparam logic [OP_W-2:0] ALU_OP_MULHSU = 6'd24;
  localparam logic [OP_W-2:0] ALU_OP_MULHU  = 6'd25;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            br_valid;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
  } alu_res_t;

endpackage

// File: rtl/alu_unit_if.sv
// Dispatch/result bus between the reservation station and the ALU stage.
// The RS side is the master; the ALU stage is the slave.
interface alu_unit_if;
  import alu_unit_pkg::*;

  logic                  rdy_in;
  logic                  clear_flag;
  logic [OP_W-1:0]       alu_op;
  logic [XLEN-1:0]       Vi;
  logic [XLEN-1:0]       Vj;
  logic [XLEN-1:0]       imm;
  logic [ROB_W-1:0]      rd;
  logic [XLEN-1:0]       pc;
  logic                  busy;
  logic                  alu_ready;
  logic [ROB_W-1:0]      alu_ROB_id;
  logic [XLEN-1:0]       alu_val;
  logic                  br_valid;
  logic                  br_taken;
  logic [XLEN-1:0]       br_target;

  modport master (
    output rdy_in, clear_flag, alu_op, Vi, Vj, imm, rd, pc,
    input  busy, alu_ready, alu_ROB_id, alu_val, br_valid, br_taken, br_target
  );

  modport slave (
    input  rdy_in, clear_flag, alu_op, Vi, Vj, imm, rd, pc,
    output busy, alu_ready, alu_ROB_id, alu_val, br_valid, br_taken, br_target
  );

endinterface

// File: rtl/alu_mul.sv
// Two-edge multiplier used when ALU_MUL_EN is defined: registers the 64-bit product
// of 33-bit sign/zero-extended operands, then selects the high or low word.
module alu_mul
  import alu_unit_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [OP_W-2:0] i_code,
  output logic [XLEN-1:0] o_res
);

  logic                    w_a_sgn;
  logic                    w_b_sgn;
  logic signed [XLEN:0]    w_a33;
  logic signed [XLEN:0]    w_b33;
  logic signed [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0]       r_prod;
  logic                    r_hi;

  assign w_a_sgn = (i_code == ALU_OP_MULH) || (i_code == ALU_OP_MULHSU);
  assign w_b_sgn = (i_code == ALU_OP_MULH);
  assign w_a33   = {w_a_sgn & i_a[XLEN-1], i_a};
  assign w_b33   = {w_b_sgn & i_b[XLEN-1], i_b};
  // 33-bit extension lets one signed multiplier cover all four variants
  assign w_prod  = w_a33 * w_b33;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_prod <= '0;
      r_hi   <= 1'b0;
    end else if (i_en) begin
      r_prod <= w_prod;
      r_hi   <= (i_code != ALU_OP_MUL);
    end
  end

  assign o_res = r_hi ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];

endmodule

// File: rtl/alu_unit.sv
// RV32I integer execution stage: computes ALU/branch/jump results and broadcasts them
// one cycle after issue. Define ALU_MUL_EN to add the two-edge multiplier (alu_mul).
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  alu_unit_if.slave bus
);

  alu_state_t       r_state, w_state_next;
  logic [OP_W-2:0]  w_code;
  logic [XLEN-1:0]  w_a, w_b;
  logic             w_accept, w_is_mul, w_taken;
  alu_res_t         w_res;

  logic             r_ready, r_bv, r_bt;
  logic [ROB_W-1:0] r_rob;
  logic [XLEN-1:0]  r_val, r_tgt;

  assign w_code   = bus.alu_op[OP_W-2:0];
  assign w_a      = bus.Vi;
  assign w_b      = bus.alu_op[ALU_USE_IMM] ? bus.imm : bus.Vj;
  assign w_accept = bus.rdy_in && !bus.clear_flag && (w_code != ALU_OP_NOP) && (r_state == ST_IDLE);

  always_comb begin
    w_taken = 1'b0;
    unique case (w_code)
      ALU_OP_BEQ:  w_taken = (w_a == w_b);
      ALU_OP_BNE:  w_taken = (w_a != w_b);
      ALU_OP_BLT:  w_taken = ($signed(w_a) < $signed(w_b));
      ALU_OP_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
      ALU_OP_BLTU: w_taken = (w_a < w_b);
      ALU_OP_BGEU: w_taken = (w_a >= w_b);
      default:     w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (w_code)
      ALU_OP_ADD:   w_res.val = w_a + w_b;
      ALU_OP_SUB:   w_res.val = w_a - w_b;
      ALU_OP_SLL:   w_res.val = w_a << w_b[4:0];
      ALU_OP_SLT:   w_res.val = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      ALU_OP_SLTU:  w_res.val = {{(XLEN-1){1'b0}}, w_a < w_b};
      ALU_OP_XOR:   w_res.val = w_a ^ w_b;
      ALU_OP_SRL:   w_res.val = w_a >> w_b[4:0];
      ALU_OP_SRA:   w_res.val = $unsigned($signed(w_a) >>> w_b[4:0]);
      ALU_OP_OR:    w_res.val = w_a | w_b;
      ALU_OP_AND:   w_res.val = w_a & w_b;
      ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT, ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU: begin
        w_res.val       = {{(XLEN-1){1'b0}}, w_taken};
        w_res.br_valid  = 1'b1;
        w_res.br_taken  = w_taken;
        w_res.br_target = w_taken ? bus.pc + bus.imm : bus.pc + 32'd4;
      end
      ALU_OP_JAL, ALU_OP_JALR: begin
        w_res.val       = bus.pc + 32'd4;
        w_res.br_valid  = 1'b1;
        w_res.br_taken  = 1'b1;
        w_res.br_target = (w_code == ALU_OP_JAL) ? bus.pc + bus.imm
                                                 : (w_a + bus.imm) & ~32'd1;
      end
      ALU_OP_LUI:   w_res.val = bus.imm;
      ALU_OP_AUIPC: w_res.val = bus.pc + bus.imm;
      default:      w_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [XLEN-1:0]  w_mul_res;
  logic [ROB_W-1:0] r_mul_rob;

  assign w_is_mul = (w_code >= ALU_OP_MUL) && (w_code <= ALU_OP_MULHU);

  alu_mul u_mul (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_en   (w_accept && w_is_mul),
    .i_a    (w_a),
    .i_b    (w_b),
    .i_code (w_code),
    .o_res  (w_mul_res)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                   r_mul_rob <= '0;
    else if (w_accept && w_is_mul) r_mul_rob <= bus.rd;
  end

  assign bus.busy = (r_state == ST_MUL);
`else
  assign w_is_mul = 1'b0;
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.rdy_in) begin
      if (bus.clear_flag) begin
        w_state_next = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (w_accept && w_is_mul) w_state_next = ST_MUL;
          ST_MUL:  w_state_next = ST_IDLE;
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ready <= 1'b0;
      r_rob   <= '0;
      r_val   <= '0;
      r_bv    <= 1'b0;
      r_bt    <= 1'b0;
      r_tgt   <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear_flag) begin
        r_ready <= 1'b0;
        r_bv    <= 1'b0;
        r_bt    <= 1'b0;
        r_tgt   <= '0;
      end else if (r_state == ST_MUL) begin
`ifdef ALU_MUL_EN
        r_ready <= 1'b1;
        r_rob   <= r_mul_rob;
        r_val   <= w_mul_res;
        r_bv    <= 1'b0;
        r_bt    <= 1'b0;
        r_tgt   <= '0;
`else
        r_ready <= 1'b0;
`endif
      end else if (w_accept && !w_is_mul) begin
        r_ready <= 1'b1;
        r_rob   <= bus.rd;
        r_val   <= w_res.val;
        r_bv    <= w_res.br_valid;
        r_bt    <= w_res.br_taken;
        r_tgt   <= w_res.br_target;
      end else begin
        r_ready <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = r_ready;
  assign bus.alu_ROB_id = r_rob;
  assign bus.alu_val    = r_val;
  assign bus.br_valid   = r_bv;
  assign bus.br_taken   = r_bt;
  assign bus.br_target  = r_tgt;

endmodule
